debug_ram_writer: RTL and testbench
===================================

// Module: debug_ram_writer
// PURPOSE
//   Write-side front end of the 1K x 8 debug RAM that the binary display scans out.
//   Accepts byte commands from a producer (UART bridge, CA engine, test logic) over valid/ready.
//   Drives the RAM write port with auto-incrementing, explicit-address and bulk-fill writes.
//   Optionally defers writes to blanking so the displayed frame never tears mid-scan.
// PARAMETERS
//   ADDR_W         10  RAM address width; depth = 2**ADDR_W
//   DATA_W         8   RAM data width
//   GATE_ON_BLANK  0   1 = RAM writes only while blank_ok=1; 0 = blank_ok ignored
// PORTS
//   clk        in   1       pixel/system clock, all logic on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       producer command valid
//   in_ready   out  1       block can accept a command this cycle
//   in_op      in   2       00 WRITE, 01 SETPTR, 10 WRITE_AT, 11 FILL
//   in_addr    in   ADDR_W  address for SETPTR / WRITE_AT
//   in_data    in   DATA_W  byte for WRITE / WRITE_AT / FILL
//   blank_ok   in   1       display in blanking (safe to write); used if GATE_ON_BLANK=1
//   ram_we     out  1       RAM write enable
//   ram_waddr  out  ADDR_W  RAM write address
//   ram_wdata  out  DATA_W  RAM write data
//   busy       out  1       FILL in progress
//   fill_done  out  1       one-cycle pulse on last FILL write
//   wr_ptr     out  ADDR_W  current auto-increment pointer
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; ram_we=0, ram_waddr=0, ram_wdata=0, busy=0,
//     fill_done=0, wr_ptr=0. Reset mid-FILL aborts immediately; no further writes.
//   gate = GATE_ON_BLANK ? blank_ok : 1.
//   States IDLE, FILL. in_ready = (state==IDLE) && gate (combinational).
//   Accept = in_valid && in_ready, sampled at rising edge. One command per accepted cycle.
//   IDLE, accept:
//     WRITE:    next cycle ram_we=1, waddr=wr_ptr, wdata=in_data; wr_ptr<=wr_ptr+1.
//     SETPTR:   wr_ptr<=in_addr; no RAM write.
//     WRITE_AT: next cycle ram_we=1, waddr=in_addr, wdata=in_data; wr_ptr<=in_addr+1.
//     FILL:     latch in_data; fill_addr<=0; go FILL; busy=1 from next cycle.
//   Write latency: accept edge -> ram_we high for exactly the following cycle (registered outputs).
//   ram_we=0 in every cycle without a pending write; waddr/wdata hold last value.
//   FILL: each cycle with gate=1 issue ram_we=1, waddr=fill_addr, wdata=latched byte,
//     fill_addr++; cycles with gate=0 stall (ram_we=0, fill_addr held).
//     Write at fill_addr=2**ADDR_W-1: fill_done=1 same cycle as that ram_we; next cycle
//     state IDLE, busy=0, wr_ptr=0. FILL of 1024 bytes, gate=1: 1024 consecutive writes.
//   Arithmetic: wr_ptr and fill_addr are ADDR_W-bit, wrap modulo 2**ADDR_W (1023+1 -> 0).
//   in_valid with in_ready=0: command held by producer, not consumed; no side effect.
//   blank_ok drop: takes effect on in_ready same cycle; a command accepted in the last
//     gated cycle still writes in the next cycle (one write may straddle gate edge by one cycle).
//   GATE_ON_BLANK=0: behaviour independent of blank_ok.
//   Display read port untouched; RAM is dual-port, read/write same address -> RAM's policy.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream -> all outputs 0 asynchronously, in_ready=1 after release.
//   2 SETPTR 0x3FE, WRITE 0xA1,0xB2,0xC3 back-to-back -> writes @0x3FE,0x3FF,0x000; wr_ptr=0x001.
//   3 WRITE_AT addr=0x155 data=0x5A, then WRITE 0x11 -> writes @0x155=0x5A, @0x156=0x11.
//   4 FILL 0xFF, gate=1 -> busy 1024 cycles, 1024 writes addr 0..1023, fill_done once at 1023,
//     in_ready=0 throughout, wr_ptr=0 after.
//   5 GATE_ON_BLANK=1, FILL 0x00 with blank_ok toggling 100 on/300 off -> no ram_we while
//     blank_ok=0 (except accept-straddle), addresses contiguous, total 1024 writes.
//   6 Random valid/op stream vs reference model of 1024-byte memory -> final contents match.

Source files
------------

// File: rtl/debug_ram_writer.sv
// debug_ram_writer: byte-command front end for the debug RAM write port (auto-increment, addressed, bulk fill),
// with optional deferral of writes to display blanking.
module debug_ram_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter bit GATE_ON_BLANK = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              blank_ok,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] wr_ptr
);
  localparam logic [1:0] OP_WRITE = 2'd0, OP_SETPTR = 2'd1, OP_WRITE_AT = 2'd2, OP_FILL = 2'd3;
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t            state_q;
  logic              we_q, fill_done_q;
  logic [ADDR_W-1:0] waddr_q, ptr_q, fill_addr_q;
  logic [DATA_W-1:0] wdata_q, fill_byte_q;
  logic              gate, accept;
  assign gate      = GATE_ON_BLANK ? blank_ok : 1'b1;
  assign in_ready  = (state_q == IDLE) && gate;
  assign accept    = in_valid && in_ready;
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q == FILL);
  assign fill_done = fill_done_q;
  assign wr_ptr    = ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      fill_done_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      fill_addr_q <= '0;
      fill_byte_q <= '0;
    end else begin
      we_q        <= 1'b0;
      fill_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          case (in_op)
            OP_WRITE: begin
              we_q    <= 1'b1;
              waddr_q <= ptr_q;
              wdata_q <= in_data;
              ptr_q   <= ptr_q + 1'b1;
            end
            OP_SETPTR: ptr_q <= in_addr;
            OP_WRITE_AT: begin
              we_q    <= 1'b1;
              waddr_q <= in_addr;
              wdata_q <= in_data;
              ptr_q   <= in_addr + 1'b1;
            end
            default: begin
              fill_byte_q <= in_data;
              fill_addr_q <= '0;
              state_q     <= FILL;
            end
          endcase
        end
      end else if (gate) begin
        // Gate low stalls the fill in place; the address only advances on an issued write.
        we_q        <= 1'b1;
        waddr_q     <= fill_addr_q;
        wdata_q     <= fill_byte_q;
        fill_addr_q <= fill_addr_q + 1'b1;
        if (fill_addr_q == LAST) begin
          fill_done_q <= 1'b1;
          state_q     <= IDLE;
          ptr_q       <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_debug_ram_writer.sv
// tb_debug_ram_writer: scoreboard bench; instance u0 ignores blank_ok, instance u1 gates writes on it.
module tb_debug_ram_writer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, blank0 = 1'b1, blank1 = 1'b1;
  logic [1:0] in_op = '0;
  logic [9:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic       rdy0, we0, busy0, fd0, rdy1, we1, busy1, fd1;
  logic [9:0] waddr0, ptr_o0, waddr1, ptr_o1;
  logic [7:0] wdata0, wdata1;
  int         pass = 0, total = 0;
  int         wr_cnt0 = 0, fd_cnt0 = 0, busy_cnt0 = 0, wr_cnt1 = 0, fd_cnt1 = 0;
  int         tog_cnt = 0;
  bit         tog = 1'b0, b1_prev = 1'b1;
  logic [17:0] q0[$], q1[$];
  logic [9:0] p0 = '0, p1 = '0;
  logic [7:0] mmem[1024], dmem[1024];

  always #5 clk = ~clk;

  debug_ram_writer #(.ADDR_W(10), .DATA_W(8), .GATE_ON_BLANK(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_op(in_op), .in_addr(in_addr),
    .in_data(in_data), .blank_ok(blank0), .ram_we(we0), .ram_waddr(waddr0), .ram_wdata(wdata0),
    .busy(busy0), .fill_done(fd0), .wr_ptr(ptr_o0));
  debug_ram_writer #(.ADDR_W(10), .DATA_W(8), .GATE_ON_BLANK(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_op(in_op), .in_addr(in_addr),
    .in_data(in_data), .blank_ok(blank1), .ram_we(we1), .ram_waddr(waddr1), .ram_wdata(wdata1),
    .busy(busy1), .fill_done(fd1), .wr_ptr(ptr_o1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin pass++; end
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input bit inst, input logic [9:0] a, input logic [7:0] d);
    if (inst) q1.push_back({a, d});
    else begin
      q0.push_back({a, d});
      mmem[a] = d;
    end
  endtask

  task automatic model(input bit inst, input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    logic [9:0] p;
    p = inst ? p1 : p0;
    case (op)
      2'd0: begin push(inst, p, d); p = p + 10'd1; end
      2'd1: p = a;
      2'd2: begin push(inst, a, d); p = a + 10'd1; end
      default: begin
        for (int i = 0; i < 1024; i++) push(inst, 10'(i), d);
        p = '0;
      end
    endcase
    if (inst) p1 = p; else p0 = p;
  endtask

  task automatic send(input bit inst, input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_op = op; in_addr = a; in_data = d;
    if (inst) v1 = 1'b1; else v0 = 1'b1;
    #1;
    while (!(inst ? rdy1 : rdy0)) begin
      n++;
      if (n > 20000) begin
        $display("FAIL accept_timeout inst=%0d got no in_ready expected in_ready=1", inst);
        $fatal(1, "accept bound expired");
      end
      @(negedge clk); #1;
    end
    model(inst, op, a, d);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic drain(input bit inst, input int bound);
    int n;
    n = 0;
    while ((inst ? q1.size() : q0.size()) != 0 && n < bound) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk(inst ? "drain1" : "drain0", inst ? q1.size() : q0.size(), 0);
  endtask

  always @(negedge clk) begin
    if (tog) begin
      blank1 = (tog_cnt % 400) < 100;
      tog_cnt++;
    end
  end

  always @(posedge clk) b1_prev = blank1;

  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (rst_n) begin
      if (we0) begin
        wr_cnt0++;
        dmem[waddr0] = wdata0;
        if (q0.size() == 0) chk("unexpected_wr0", {waddr0, wdata0}, 18'h3ffff);
        else begin
          e = q0.pop_front();
          chk("wr0", {waddr0, wdata0}, e);
        end
      end
      if (fd0) begin
        fd_cnt0++;
        chk("fill_done_at_last0", {we0, waddr0}, {1'b1, 10'h3ff});
      end
      if (busy0) busy_cnt0++;
      chk("ready_vs_busy0", rdy0, !busy0);
      if (we1) begin
        wr_cnt1++;
        chk("gated_wr1", b1_prev, 1'b1);
        if (q1.size() == 0) chk("unexpected_wr1", {waddr1, wdata1}, 18'h3ffff);
        else begin
          e = q1.pop_front();
          chk("wr1", {waddr1, wdata1}, e);
        end
      end
      if (fd1) begin
        fd_cnt1++;
        chk("fill_done_at_last1", {we1, waddr1}, {1'b1, 10'h3ff});
      end
      chk("ready_vs_busy1", rdy1, !busy1 && blank1);
    end
  end

  initial begin
    logic [1:0] op;
    #2;
    chk("reset_out0", {we0, waddr0, wdata0, busy0, fd0, ptr_o0}, '0);
    chk("reset_out1", {we1, waddr1, wdata1, busy1, fd1, ptr_o1}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", rdy0, 1'b1);
    send(0, 2'd1, 10'h3fe, 8'h00);
    send(0, 2'd0, 10'h000, 8'ha1);
    send(0, 2'd0, 10'h000, 8'hb2);
    send(0, 2'd0, 10'h000, 8'hc3);
    drain(0, 20);
    chk("ptr_wrap", ptr_o0, 10'h001);
    send(0, 2'd2, 10'h155, 8'h5a);
    send(0, 2'd0, 10'h000, 8'h11);
    drain(0, 20);
    chk("ptr_after_write_at", ptr_o0, 10'h157);
    chk("mem_155", dmem[10'h155], 8'h5a);
    chk("mem_156", dmem[10'h156], 8'h11);
    busy_cnt0 = 0; fd_cnt0 = 0; wr_cnt0 = 0;
    blank0 = 1'b0;
    send(0, 2'd3, 10'h000, 8'hff);
    drain(0, 2000);
    chk("fill_busy_cycles", busy_cnt0, 1024);
    chk("fill_writes", wr_cnt0, 1024);
    chk("fill_done_pulses", fd_cnt0, 1);
    chk("fill_ptr", ptr_o0, 10'h000);
    send(0, 2'd1, 10'h2aa, 8'h00);
    send(0, 2'd3, 10'h000, 8'h77);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_fill", {we0, waddr0, wdata0, busy0, fd0, ptr_o0}, '0);
    q0.delete(); p0 = '0;
    repeat (3) @(negedge clk);
    chk("no_write_in_reset", we0, 1'b0);
    rst_n = 1'b1;
    #1 chk("ready_after_midreset", {rdy0, busy0}, 2'b10);
    wr_cnt1 = 0; fd_cnt1 = 0;
    tog_cnt = 0; tog = 1'b1;
    send(1, 2'd3, 10'h000, 8'h00);
    drain(1, 10000);
    tog = 1'b0;
    chk("gated_fill_writes", wr_cnt1, 1024);
    chk("gated_fill_done", fd_cnt1, 1);
    chk("gated_fill_ptr", ptr_o1, 10'h000);
    for (int i = 0; i < 1024; i++) begin mmem[i] = 8'h00; dmem[i] = 8'h00; end
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      blank0 = 1'($urandom);
      op = ($urandom_range(0, 63) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(0, op, 10'($urandom), 8'($urandom));
    end
    drain(0, 3000);
    chk("random_ptr", ptr_o0, p0);
    for (int i = 0; i < 1024; i++) chk("random_mem", {i[9:0], dmem[i]}, {i[9:0], mmem[i]});
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
